// File: rtl/mem_arbiter.sv
// Two-port (fetch I / load-store D) arbiter in front of a single-port synchronous memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    // Handshake: a requester holds req and its fields until it sees its gnt pulse;
    // gnt coincides with mem_en, and the owner's rvalid follows one cycle later.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    logic   owner_d;
    logic   any_req;
    logic   pick_d;

`ifdef MEM_ARB_RR_EN
    logic last_d;
`endif

    assign any_req = i_req | d_req;

`ifdef MEM_ARB_RR_EN
    // On a tie the port that was not granted last wins; a lone requester always wins.
    assign pick_d = (i_req && d_req) ? !last_d : d_req;
`else
    assign pick_d = d_req;
`endif

    // Synchronous memory read data is valid in RESP, so it is passed straight through.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            last_d    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE, RESP: begin
                    i_rvalid <= 1'b0;
                    d_rvalid <= 1'b0;
                    if (any_req) begin
                        state   <= ACCESS;
                        mem_en  <= 1'b1;
                        i_gnt   <= !pick_d;
                        d_gnt   <= pick_d;
                        owner_d <= pick_d;
`ifdef MEM_ARB_RR_EN
                        last_d  <= pick_d;
`endif
                        if (pick_d) begin
                            mem_we    <= d_we;
                            mem_be    <= d_be;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_be    <= '1;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                        end
                    end else begin
                        state  <= IDLE;
                        i_gnt  <= 1'b0;
                        d_gnt  <= 1'b0;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                    end
                end
                ACCESS: begin
                    state    <= RESP;
                    i_gnt    <= 1'b0;
                    d_gnt    <= 1'b0;
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    i_rvalid <= !owner_d;
                    d_rvalid <= owner_d;
                end
                default: begin
                    state    <= IDLE;
                    i_gnt    <= 1'b0;
                    d_gnt    <= 1'b0;
                    i_rvalid <= 1'b0;
                    d_rvalid <= 1'b0;
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule
